// File: rtl/ccg_eval_sched.sv
// Round-robin scheduler sharing one combinational benchmark circuit among NREQ requesters.
// Define CCG_EVAL_STATS_EN to add per-requester completed-response counters (txn_count).
module ccg_eval_sched #(
    parameter int NREQ   = 4,
    parameter int IN_W   = 30,
    parameter int OUT_W  = 18,
    parameter int SETTLE = 2
`ifdef CCG_EVAL_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*IN_W-1:0]      req_vec,
    output logic [IN_W-1:0]           cut_x,
    input  logic [OUT_W-1:0]          cut_f,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [OUT_W-1:0]          rsp_f,
    output logic                      busy
`ifdef CCG_EVAL_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]     txn_count
`endif
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int SCNT_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [SCNT_W-1:0] scnt;
    logic              grant_hit;
    logic [ID_W-1:0]   grant_idx;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_hit && req_valid[(int'(ptr) + k) % NREQ]) begin
                grant_hit = 1'b1;
                grant_idx = ID_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_hit && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(NREQ - 1);
            scnt      <= '0;
            cut_x     <= '0;
            rsp_f     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_hit) begin
                        cut_x  <= req_vec[grant_idx*IN_W +: IN_W];
                        rsp_id <= grant_idx;
                        ptr    <= grant_idx;
                        scnt   <= '0;
                        busy   <= 1'b1;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    scnt <= scnt + 1'b1;
                    // cut_x has been stable for SETTLE cycles at this edge.
                    if (scnt == SCNT_W'(SETTLE - 1)) begin
                        rsp_f     <= cut_f;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CCG_EVAL_STATS_EN
    logic [CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == S_RESP && rsp_ready) begin
            cnt[rsp_id] <= cnt[rsp_id] + 1'b1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        assign txn_count[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_ccg_eval_sched.sv
// Self-checking bench for ccg_eval_sched: directed and random transactions against a
// behavioural scheduler/circuit model; a second SETTLE=1 instance checks short-window timing.
module tb_ccg_eval_sched;

    localparam int NREQ  = 4;
    localparam int IN_W  = 30;
    localparam int OUT_W = 18;
    localparam int SETTLE = 2;
    localparam int CNTW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*IN_W-1:0]  req_vec;
    logic [IN_W-1:0]       cut_x;
    logic [OUT_W-1:0]      cut_f;
    logic                  rsp_valid, rsp_ready;
    logic [1:0]            rsp_id;
    logic [OUT_W-1:0]      rsp_f;
    logic                  busy;

    logic [NREQ-1:0]       req_valid1, req_ready1;
    logic [NREQ*IN_W-1:0]  req_vec1;
    logic [IN_W-1:0]       cut_x1;
    logic [OUT_W-1:0]      cut_f1;
    logic                  rsp_valid1, rsp_ready1;
    logic [1:0]            rsp_id1;
    logic [OUT_W-1:0]      rsp_f1;
    logic                  busy1;

`ifdef CCG_EVAL_STATS_EN
    logic [NREQ*CNTW-1:0]  txn_count, txn_count1;
`endif

    // Benchmark circuit model: f1 = x21 ^ (x2 & x12), f8 = x14, several outputs mirror f1.
    function automatic logic [OUT_W-1:0] circ(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] f;
        logic f1;
        f1 = x[21] ^ (x[2] & x[12]);
        f = '0;
        for (int i = 0; i <= 6; i++) f[i] = f1;
        f[7]  = x[14];
        f[8]  = x[0];
        f[9]  = x[1] ^ x[3];
        f[10] = x[5] & x[6];
        f[11] = f1;
        f[12] = x[7] | x[8];
        f[13] = f1;
        f[14] = f1;
        f[15] = x[29];
        f[16] = ^x[20:16];
        f[17] = x[28] & x[27];
        return f;
    endfunction

    assign cut_f  = circ(cut_x);
    assign cut_f1 = circ(cut_x1);

    ccg_eval_sched #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)
`ifdef CCG_EVAL_STATS_EN
        , .CNT_W(CNTW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_vec(req_vec), .cut_x(cut_x), .cut_f(cut_f), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f), .busy(busy)
`ifdef CCG_EVAL_STATS_EN
        , .txn_count(txn_count)
`endif
    );

    ccg_eval_sched #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)
`ifdef CCG_EVAL_STATS_EN
        , .CNT_W(CNTW)
`endif
    ) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_vec(req_vec1), .cut_x(cut_x1), .cut_f(cut_f1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready1), .rsp_id(rsp_id1), .rsp_f(rsp_f1), .busy(busy1)
`ifdef CCG_EVAL_STATS_EN
        , .txn_count(txn_count1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int model_ptr;
    int exp_cnt [NREQ];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next winner: lowest requesting index above the last winner, else lowest overall.
    function automatic int pick(input int ptr, input logic [NREQ-1:0] mask);
        for (int i = ptr + 1; i < NREQ; i++) if (mask[i]) return i;
        for (int i = 0; i <= ptr; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic rand_vecs();
        for (int i = 0; i < NREQ; i++) req_vec[i*IN_W +: IN_W] = IN_W'($urandom);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        req_valid = '0;
        req_valid1 = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cut_x", cut_x, 0);
        checkOutput("rst_rsp_f", rsp_f, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
    endtask

    // One full transaction from an idle DUT; bp = cycles rsp_ready is held low in RESP.
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int bp,
                                 output logic [OUT_W-1:0] obs_f);
        int g;
        logic [IN_W-1:0] v;
        req_valid = mask;
        rsp_ready = (bp == 0);
        #1;
        g = pick(model_ptr, mask);
        checkOutput("grant", req_ready, 64'(1) << g);
        checkOutput("busy_idle", busy, 0);
        v = req_vec[g*IN_W +: IN_W];
        step();
        model_ptr = g;
        for (int c = 1; c <= SETTLE; c++) begin
            checkOutput("settle_rsp_valid", rsp_valid, 0);
            checkOutput("settle_req_ready", req_ready, 0);
            checkOutput("settle_cut_x", cut_x, v);
            checkOutput("settle_busy", busy, 1);
            step();
        end
        obs_f = '0;
        for (int b = 0; b <= bp; b++) begin
            rsp_ready = (b == bp);
            checkOutput("resp_valid", rsp_valid, 1);
            checkOutput("resp_id", rsp_id, g);
            checkOutput("resp_f", rsp_f, circ(v));
            checkOutput("resp_req_ready", req_ready, 0);
            checkOutput("resp_cut_x", cut_x, v);
            obs_f = rsp_f;
            step();
        end
        exp_cnt[g] = (exp_cnt[g] + 1) % (1 << CNTW);
        req_valid = '0;
        checkOutput("post_rsp_valid", rsp_valid, 0);
        checkOutput("post_busy", busy, 0);
    endtask

    initial begin
        logic [OUT_W-1:0] f;
        logic [IN_W-1:0]  v;
        rst = 1'b1;
        req_valid = '0;
        req_vec = '0;
        rsp_ready = 1'b1;
        req_valid1 = '0;
        req_vec1 = '0;
        rsp_ready1 = 1'b1;
        applyReset();

        // Short settle window: response must appear in cycle 2.
        for (int i = 0; i < NREQ; i++) req_vec1[i*IN_W +: IN_W] = IN_W'($urandom);
        v = req_vec1[1*IN_W +: IN_W];
        req_valid1 = 4'b0010;
        #1;
        checkOutput("s1_grant", req_ready1, 4'b0010);
        step();
        req_valid1 = '0;
        checkOutput("s1_c1_valid", rsp_valid1, 0);
        checkOutput("s1_cut_x", cut_x1, v);
        step();
        checkOutput("s1_c2_valid", rsp_valid1, 1);
        checkOutput("s1_rsp_id", rsp_id1, 1);
        checkOutput("s1_rsp_f", rsp_f1, circ(v));
        step();
        checkOutput("s1_c3_valid", rsp_valid1, 0);

        // Single request: f1 = 0 ^ (1 & 1) = 1, f8 = 0.
        req_vec = '0;
        v = '0;
        v[2] = 1'b1;
        v[12] = 1'b1;
        req_vec[0 +: IN_W] = v;
        applyStimulus(4'b0001, 0, f);
        checkOutput("single_f1", f[0], 1);
        checkOutput("single_f8", f[7], 0);

        // Round robin from reset with all requesters active.
        applyReset();
        for (int n = 0; n < 5; n++) begin
            rand_vecs();
            applyStimulus(4'b1111, 0, f);
        end

        rand_vecs();
        applyStimulus(4'b1111, 10, f);

        // Capture: f1 = 1 ^ (0 & x12) = 1, f8 = 1.
        rand_vecs();
        v = req_vec[0 +: IN_W];
        v[21] = 1'b1;
        v[2] = 1'b0;
        v[14] = 1'b1;
        req_vec[0 +: IN_W] = v;
        applyStimulus(4'b0001, 0, f);
        checkOutput("cap_f1", f[0], 1);
        checkOutput("cap_f8", f[7], 1);

        for (int n = 0; n < 20; n++) begin
            rand_vecs();
            applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 3), f);
        end

        // Reset during SETTLE aborts the transaction and restores requester-0 priority.
        rand_vecs();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checkOutput("mid_grant", req_ready, 64'(1) << pick(model_ptr, 4'b1111));
        step();
        checkOutput("mid_busy_settle", busy, 1);
        rst = 1'b1;
        step();
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_cut_x", cut_x, 0);
        checkOutput("mid_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        model_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
        applyStimulus(4'b1111, 0, f);

`ifdef CCG_EVAL_STATS_EN
        applyReset();
        for (int n = 0; n < 17; n++) begin
            rand_vecs();
            applyStimulus(4'b0100, 0, f);
        end
        for (int i = 0; i < NREQ; i++) begin
            checkOutput("txn_count", txn_count[i*CNTW +: CNTW], exp_cnt[i]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccg_eval_sched.md
# ccg_eval_sched

Round-robin scheduler that shares one combinational benchmark circuit (30 inputs x0..x29, 18 outputs f1..f18) among several requesters. It accepts a requester's input vector and drives it onto the circuit inputs. It holds the vector for a fixed settle window, captures the circuit outputs, and returns them tagged with the requester index. It sits between test/feature-extraction agents and the netlist under evaluation, so that only one vector is applied at a time.

## Interface
- NREQ, 4, number of requesters (2..8)
- IN_W, 30, circuit input width (x0 = bit 0)
- OUT_W, 18, circuit output width (f1 = bit 0)
- SETTLE, 2, cycles the vector is held before capture (>=1)
- CNT_W, 16, width of per-requester transaction counters (stats build only)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high
- req_vec  in  NREQ*IN_W  requester i vector at [i*IN_W +: IN_W]
- cut_x  out  IN_W  registered drive to circuit inputs
- cut_f  in  OUT_W  circuit outputs (combinational from cut_x)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NREQ)  requester index of the response
- rsp_f  out  OUT_W  captured circuit outputs
- busy  out  1  high in every state except IDLE
- txn_count  out  NREQ*CNT_W  completed-response counters (only with CCG_EVAL_STATS_EN)

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from (ptr+1) mod NREQ.
  - req_ready[g] is high combinationally in this cycle, and the handshake completes in the same cycle.
  - At the clock edge: cut_x <= vector g, rsp_id <= g, ptr <= g, scnt <= 0, go to SETTLE.
- SETTLE:
  - Increment scnt each cycle.
  - When scnt == SETTLE-1: rsp_f <= cut_f, go to RESP.
- RESP:
  - rsp_valid is high. rsp_id and rsp_f stay stable until rsp_ready is sampled high; then go to IDLE.
- req_ready is 0 in SETTLE and RESP. No new grant is made in the cycle a response handshake completes.
- cut_x holds the last applied vector while idle. It changes only at the acceptance edge, so the circuit sees no spurious inputs.
- Deasserting req_valid without a grant is legal. The pointer moves only on a grant.
- Reset values:
  - state IDLE
  - ptr = NREQ-1, so requester 0 has first priority
  - cut_x = 0, rsp_f = 0, rsp_id = 0
  - rsp_valid = 0, req_ready = 0, busy = 0
  - counters = 0
- Reset asserted mid-transaction aborts it: no response is issued and no counter is incremented.

## Timing
- Acceptance in cycle 0. cut_x is valid from cycle 1. The capture edge is at the end of cycle SETTLE. rsp_valid rises in cycle SETTLE+1.
- Minimum issue interval is SETTLE+2 cycles: accept, SETTLE cycles, one RESP cycle with rsp_ready high. The next grant is possible in the following cycle.
- Back-pressure on rsp_ready stretches RESP indefinitely. cut_x stays unchanged throughout.
- scnt width is clog2(SETTLE+1). It does not wrap within a transaction.

## Configuration
- CCG_EVAL_STATS_EN defined:
  - txn_count[i] increments by 1 (mod 2^CNT_W, wraps to 0) on each completed response handshake for requester i.
  - Counters are cleared by rst.
- Undefined: the txn_count port and counters are absent. All other behaviour is identical.

## Test plan
Bench circuit model: f1 = x21 ^ (x2 & x12), f8 = x14, and f2..f7, f12, f14, f15 = f1. SETTLE=2, NREQ=4 unless stated.
- Single request, idle bus:
  - Stimulus: req0 vector with x2=1, x12=1, x21=0, x14=0 at cycle 0.
  - Required: req_ready[0]=1 in cycle 0; cut_x updated in cycle 1; rsp_valid=1 in cycle 3; rsp_id=0; rsp_f bit0=1, bit7=0.
- Round robin:
  - Stimulus: all four req_valid held high.
  - Required: grants in order 0,1,2,3,0. One grant every 4 cycles with rsp_ready tied high.
- Back-pressure:
  - Stimulus: rsp_ready low for 10 cycles.
  - Required: rsp_valid, rsp_id and rsp_f stable; req_ready all 0; cut_x unchanged. Next grant only in the cycle after rsp_ready is sampled high.
- Capture timing:
  - Stimulus: vector with x21=1, x2=0 and x14=1, with cut_f sampled through the model.
  - Required: rsp_f bit0=1, bit7=1. Repeat with SETTLE=1; rsp_valid must rise in cycle 2.
- Mid-operation reset:
  - Stimulus: assert rst in the SETTLE state.
  - Required: no rsp_valid; busy=0, cut_x=0 the cycle after rst is sampled; next grant goes to requester 0.
- Stats (with CCG_EVAL_STATS_EN, CNT_W=4):
  - Stimulus: 17 responses for requester 2.
  - Required: txn_count[2]=1 (wrapped); the other counters are 0.
